// File: rtl/tetris_pkg.sv
// Shared types and defaults for the playfield stack.
package tetris_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FILL,
    DONE
  } stack_state_t;

  localparam int unsigned DEF_COLS = 10;
  localparam int unsigned DEF_ROWS = 20;

  // 16-bit add that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? '1 : s[15:0];
  endfunction

endpackage

// File: rtl/stack_row.sv
// One playfield row: clear beats load beats OR-write; full when every cell is set.
module stack_row #(
  parameter int unsigned COLS = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            load,
  input  logic [COLS-1:0] load_data,
  input  logic            wr_en,
  input  logic [COLS-1:0] wr_data,
  output logic [COLS-1:0] q,
  output logic            full
);

  // Row storage with prioritised clear / load / OR-merge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (wr_en) begin
      q <= q | wr_data;
    end
  end

  assign full = (q == '1);

endmodule

// File: rtl/playfield_stack.sv
// Playfield stack: OR-writes of piece cells, full-row removal pass with compaction.
module playfield_stack
  import tetris_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_valid,
  input  logic [$clog2(ROWS)-1:0]   wr_idx,
  input  logic [COLS-1:0]           wr_data,
  output logic                      wr_ready,
  output logic                      wr_collide,
  input  logic                      clr_start,
  output logic                      busy,
  output logic                      clr_done,
  output logic [$clog2(ROWS+1)-1:0] lines_cleared,
  output logic [15:0]               total_lines,
  input  logic [$clog2(ROWS)-1:0]   rd_idx,
  output logic [COLS-1:0]           rd_data,
  output logic                      bad_idx
);

  localparam int unsigned IW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(ROWS+1);
  localparam logic [IW:0] ROWS_W = (IW+1)'(ROWS);

  stack_state_t    state;
  logic [IW-1:0]   src;
  logic [CW-1:0]   dst;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;

  logic [COLS-1:0] row_q [ROWS];
  logic [ROWS-1:0] row_full;
  logic [ROWS-1:0] row_clr;
  logic [ROWS-1:0] row_load;
  logic [ROWS-1:0] row_wr;

  logic            idx_ok;
  logic            wr_acc;
  logic            src_full;
  logic [COLS-1:0] src_row;
  logic [COLS-1:0] wr_row;
  logic [COLS-1:0] rd_row;

  assign wr_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign idx_ok     = ({1'b0, wr_idx} < ROWS_W);
  assign wr_acc     = wr_valid && wr_ready && idx_ok;
  assign count_next = count + CW'(src_full);

  // Row selection muxes for the scan source, write target and read port
  always_comb begin
    src_row  = '0;
    src_full = 1'b0;
    wr_row   = '0;
    rd_row   = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (src == IW'(i)) begin
        src_row  = row_q[i];
        src_full = row_full[i];
      end
      if (wr_idx == IW'(i)) wr_row = row_q[i];
      if (rd_idx == IW'(i)) rd_row = row_q[i];
    end
  end

  // Per-row controls: compaction copies surviving rows down to dst, fill zeroes the top
  always_comb begin
    row_clr  = '0;
    row_load = '0;
    row_wr   = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      row_clr[i]  = (state == FILL) && (dst == CW'(i));
      row_load[i] = (state == SCAN) && !src_full && (dst == CW'(i));
      row_wr[i]   = wr_acc && (wr_idx == IW'(i));
    end
  end

  for (genvar g = 0; g < ROWS; g++) begin : g_row
    stack_row #(.COLS(COLS)) u_row (
      .clk       (clk),
      .reset     (reset),
      .clr       (row_clr[g]),
      .load      (row_load[g]),
      .load_data (src_row),
      .wr_en     (row_wr[g]),
      .wr_data   (wr_data),
      .q         (row_q[g]),
      .full      (row_full[g])
    );
  end

  // Clear-pass sequencer and registered status outputs.
  // Results are loaded on entry to DONE so they are valid while clr_done is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      src           <= '0;
      dst           <= '0;
      count         <= '0;
      clr_done      <= 1'b0;
      lines_cleared <= '0;
      total_lines   <= '0;
      wr_collide    <= 1'b0;
      bad_idx       <= 1'b0;
    end else begin
      wr_collide <= 1'b0;
      clr_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_valid) begin
            if (!idx_ok) bad_idx <= 1'b1;
            else         wr_collide <= |(wr_row & wr_data);
          end
          if (clr_start) begin
            state <= SCAN;
            src   <= '0;
            dst   <= '0;
            count <= '0;
          end
        end
        SCAN: begin
          count <= count_next;
          if (!src_full) dst <= dst + 1'b1;
          src <= src + 1'b1;
          if (src == IW'(ROWS-1)) begin
            if (count_next == '0) begin
              state         <= DONE;
              clr_done      <= 1'b1;
              lines_cleared <= '0;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          dst <= dst + 1'b1;
          if (dst == CW'(ROWS-1)) begin
            state         <= DONE;
            clr_done      <= 1'b1;
            lines_cleared <= count;
            total_lines   <= sat_add16(total_lines, 16'(count));
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered read port; out-of-range indices read as zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_row;
  end

endmodule

// File: tb/tb_playfield_stack.sv
// Self-checking bench for playfield_stack against a row-array reference model.
module tb_playfield_stack;

  localparam int COLS = 10;
  localparam int ROWS = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [4:0]  wr_idx = '0;
  logic [9:0]  wr_data = '0;
  logic        wr_ready;
  logic        wr_collide;
  logic        clr_start = 1'b0;
  logic        busy;
  logic        clr_done;
  logic [4:0]  lines_cleared;
  logic [15:0] total_lines;
  logic [4:0]  rd_idx = '0;
  logic [9:0]  rd_data;
  logic        bad_idx;

  int total = 0;
  int bad = 0;

  logic [9:0] mrow [ROWS];
  int         mtotal;
  bit         mbad;

  always #5 clk = ~clk;

  playfield_stack #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_idx        (wr_idx),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .wr_collide    (wr_collide),
    .clr_start     (clr_start),
    .busy          (busy),
    .clr_done      (clr_done),
    .lines_cleared (lines_cleared),
    .total_lines   (total_lines),
    .rd_idx        (rd_idx),
    .rd_data       (rd_data),
    .bad_idx       (bad_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) mrow[r] = '0;
    mtotal = 0;
    mbad   = 1'b0;
  endtask

  // Remove full rows, keep survivors in order from the bottom, pad with empties
  function automatic int model_clear();
    logic [9:0] keep [$];
    int cnt;
    cnt = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (mrow[r] == 10'h3FF) cnt++;
      else keep.push_back(mrow[r]);
    end
    for (int r = 0; r < ROWS; r++) mrow[r] = (r < keep.size()) ? keep[r] : 10'h000;
    mtotal = (mtotal + cnt > 65535) ? 65535 : mtotal + cnt;
    return cnt;
  endfunction

  task automatic do_write(input int idx, input logic [9:0] data, output bit exp_col);
    exp_col = 1'b0;
    wr_valid = 1'b1;
    wr_idx   = 5'(idx);
    wr_data  = data;
    if (idx < ROWS) begin
      exp_col   = (mrow[idx] & data) != 10'h000;
      mrow[idx] = mrow[idx] | data;
    end else begin
      mbad = 1'b1;
    end
    step();
    wr_valid = 1'b0;
    check("wr_collide", wr_collide, exp_col);
    check("bad_idx", bad_idx, mbad);
  endtask

  task automatic check_rows();
    for (int r = 0; r < ROWS; r++) begin
      rd_idx = 5'(r);
      if (r > 0) begin
        #1;
        check("rd_latency", rd_data, mrow[r-1]);
      end
      step();
      check($sformatf("row%0d", r), rd_data, mrow[r]);
    end
    rd_idx = 5'd25;
    step();
    check("rd_oob", rd_data, 0);
  endtask

  // Start a pass (optionally with a same-cycle write), poke ignored requests mid-pass
  task automatic do_clear(input bit with_wr, input int widx, input logic [9:0] wdata);
    int  n;
    int  cnt;
    bit  seen;
    if (with_wr) begin
      wr_valid = 1'b1;
      wr_idx   = 5'(widx);
      wr_data  = wdata;
      mrow[widx] = mrow[widx] | wdata;
    end
    cnt = model_clear();
    clr_start = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 80) begin
      step();
      n++;
      clr_start = 1'b0;
      wr_valid  = 1'b0;
      if (n == 1) check("busy_in_pass", busy, 1);
      if (n == 3) begin
        wr_valid = 1'b1;
        wr_idx   = 5'($urandom_range(0, ROWS-1));
        wr_data  = 10'($urandom);
      end
      if (n == 5) clr_start = 1'b1;
      if (clr_done) seen = 1'b1;
    end
    clr_start = 1'b0;
    wr_valid  = 1'b0;
    check("clr_latency", n, ROWS + cnt + 1);
    check("lines_cleared", lines_cleared, cnt);
    check("total_lines", total_lines, mtotal);
    step();
    check("done_width", clr_done, 0);
    step();
    check("idle_after", busy, 0);
  endtask

  initial begin
    bit col;
    int cyc_done;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_wr_ready", wr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_total", total_lines, 0);
    check("rst_lines", lines_cleared, 0);
    check("rst_bad", bad_idx, 0);
    check("rst_collide", wr_collide, 0);
    check("rst_done", clr_done, 0);
    check("rst_rd", rd_data, 0);

    // empty stack pass
    do_clear(1'b0, 0, '0);
    check_rows();

    // two full rows interleaved with partial rows
    do_write(0, 10'h3FF, col);
    do_write(1, 10'h001, col);
    do_write(2, 10'h3FF, col);
    do_write(3, 10'h200, col);
    do_clear(1'b0, 0, '0);
    check_rows();

    // overlapping write raises one collide pulse
    do_write(5, 10'h00F, col);
    do_write(5, 10'h018, col);
    check("collide_expect", col, 1);
    step();
    check("collide_once", wr_collide, 0);

    // same-cycle write completes row 0 before the scan
    do_write(0, 10'h3C0, col);
    do_clear(1'b1, 0, 10'h3FF);
    check_rows();

    // out-of-range write
    do_write(25, 10'h3FF, col);
    check_rows();

    // random fills and passes
    for (int round = 0; round < 6; round++) begin
      for (int k = 0; k < 10; k++) begin
        do_write($urandom_range(0, ROWS+1),
                 ($urandom_range(0, 1) == 1) ? 10'h3FF : 10'($urandom), col);
      end
      do_clear(1'b0, 0, '0);
      check_rows();
    end

    // saturation of the running total
    force dut.total_lines = 16'hFFFE;
    step();
    release dut.total_lines;
    step();
    check("total_preset", total_lines, 16'hFFFE);
    mtotal = 16'hFFFE;
    for (int r = 0; r < 4; r++) do_write(r, 10'h3FF, col);
    do_clear(1'b0, 0, '0);
    check("total_sat", total_lines, 16'hFFFF);
    check_rows();

    // reset in the middle of a pass
    do_write(2, 10'h3FF, col);
    do_write(4, 10'h0F0, col);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (5) step();
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_done", clr_done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_total", total_lines, 0);
    model_reset();
    step();
    step();
    reset = 1'b0;
    cyc_done = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (clr_done) cyc_done++;
    end
    check("no_done_after_rst", cyc_done, 0);
    check("rst_ready2", wr_ready, 1);
    check("rst_bad2", bad_idx, 0);
    check_rows();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/playfield_stack.md
PLAYFIELD_STACK -- requirements
Module: playfield_stack

Interface
REQ-001 Parameter COLS, default 10, cells per row.
REQ-002 Parameter ROWS, default 20, row count; row 0 is the bottom.
REQ-003 clk  input  1  clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 wr_valid  input  1  write request; data is ORed into one row.
REQ-006 wr_idx  input  $clog2(ROWS)  target row index.
REQ-007 wr_data  input  COLS  cell mask to OR into the target row.
REQ-008 wr_ready  output  1  high only in IDLE.
REQ-009 wr_collide  output  1  one-cycle pulse, the cycle after an accepted write that overlapped occupied cells.
REQ-010 clr_start  input  1  starts a full-row clear pass; sampled only in IDLE.
REQ-011 busy  output  1  high in SCAN, FILL and DONE.
REQ-012 clr_done  output  1  one-cycle pulse when a clear pass ends.
REQ-013 lines_cleared  output  $clog2(ROWS+1)  rows removed by the last pass.
REQ-014 total_lines  output  16  saturating running total of cleared rows.
REQ-015 rd_idx  input  $clog2(ROWS)  read row index.
REQ-016 rd_data  output  COLS  registered contents of row rd_idx.
REQ-017 bad_idx  output  1  sticky flag, set by any accepted write with wr_idx >= ROWS.

Function
REQ-018 The block SHALL hold ROWS registers of COLS bits each.
REQ-019 A row SHALL be full when all COLS bits are 1, i.e. equal to the COLS-wide all-ones value; no fixed-width constant.
REQ-020 Accepted write (wr_valid & wr_ready, wr_idx < ROWS): row[wr_idx] <= row[wr_idx] | wr_data.
REQ-021 wr_collide SHALL pulse the next cycle iff (row[wr_idx] & wr_data) != 0 before the write.
REQ-022 A write with wr_idx >= ROWS SHALL leave all rows unchanged and SHALL set bad_idx.
REQ-023 wr_valid SHALL be ignored while wr_ready is low; no queuing.
REQ-024 State machine states: IDLE, SCAN, FILL, DONE.
REQ-025 IDLE -> SCAN on clr_start; on entry src=0, dst=0, count=0.
REQ-026 SCAN, one row per cycle:
- If row[src] is full: count++.
- Otherwise: row[dst] <= row[src], dst++.
- Then src++.
- When src = ROWS-1 is processed, go to FILL.
REQ-027 FILL SHALL zero row[dst] and increment dst once per cycle while dst < ROWS, then go to DONE; with count 0, FILL lasts 0 cycles.
REQ-028 DONE lasts one cycle:
- pulses clr_done;
- loads lines_cleared = count;
- adds count to total_lines, saturating at 16'hFFFF;
- returns to IDLE.
REQ-029 Pass latency SHALL be exactly ROWS + count + 1 cycles from the clr_start cycle to the clr_done pulse.
REQ-030 Multiple full rows, adjacent or not, SHALL all clear in one pass; surviving rows keep their relative order.
REQ-031 clr_start with wr_valid in the same IDLE cycle: the write commits first, and SCAN sees the written data.
REQ-032 clr_start while busy SHALL be ignored.
REQ-033 rd_data SHALL equal row[rd_idx] as of the previous cycle (1-cycle latency) in every state.
REQ-034 rd_data SHALL read 0 when rd_idx >= ROWS.

Reset
REQ-035 reset SHALL asynchronously force:
- all rows = 0, state = IDLE;
- lines_cleared, total_lines, wr_collide, clr_done, bad_idx, rd_data = 0;
- wr_ready = 1 after release.
REQ-036 Reset during SCAN or FILL SHALL abort the pass with no clr_done pulse and no total_lines update.

Structure
REQ-037 Package tetris_pkg SHALL hold the state enum (IDLE/SCAN/FILL/DONE) and the default COLS/ROWS constants.
REQ-038 One sub-module, stack_row: a COLS-wide register with load, OR-write, clear and a combinational full output, instanced ROWS times.

Verification (COLS=10, ROWS=20)
REQ-039 Empty stack, clr_start -> clr_done at cycle 21, lines_cleared=0, all rows 0.
REQ-040 Rows 0 and 2 = 10'h3FF, row 1 = 10'h001, row 3 = 10'h200, clr_start -> done at cycle 23; row0=10'h001, row1=10'h200, rows 2-19 = 0, lines_cleared=2.
REQ-041 Row 5 = 10'h00F, write idx 5 data 10'h018 -> row5=10'h01F, wr_collide pulses once.
REQ-042 Same-cycle write of idx 0 data 10'h3FF (row 0 was 10'h3C0) and clr_start -> row 0 cleared, lines_cleared=1.
REQ-043 Write wr_idx=25 -> bad_idx=1, no row changes; reset mid-SCAN -> all rows 0, no clr_done pulse.
REQ-044 total_lines preset near 16'hFFFE, then a 4-line clear -> total_lines=16'hFFFF.
